// File: rtl/div_recombiner.sv
// Sequential shift-add reconstruction of a dividend: a = q*b + r.
// One partial product per cycle, fixed 5-cycle run, one-cycle ready pulse.
module div_recombiner (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] q,
    input  logic [4:0] b,
    input  logic [4:0] r,
    output logic       busy,
    output logic       ready,
    output logic [9:0] a
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [9:0] mcand_q, mcand_d;
    logic [4:0] mplier_q, mplier_d;
    logic [2:0] cnt_q, cnt_d;
    logic [9:0] a_q, a_d;
    logic [9:0] acc_sum;

    // Max result is 31*31+31 = 992, so the 10-bit sum never wraps.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 10'd0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d    = {5'b0, r};
                    mcand_d  = {5'b0, b};
                    mplier_d = q;
                    cnt_d    = 3'd0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[8:0], 1'b0};
                mplier_d = {1'b0, mplier_q[4:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    a_d     = acc_sum;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= 10'd0;
            mcand_q  <= 10'd0;
            mplier_q <= 5'd0;
            cnt_q    <= 3'd0;
            a_q      <= 10'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign ready = (state_q == StDone);
    assign a     = a_q;

endmodule

// File: tb/tb_div_recombiner.sv
// Directed bench for div_recombiner: latency, hold behaviour, start-ignore and reset abort.
module tb_div_recombiner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] q, b, r;
    logic       busy, ready;
    logic [9:0] a;

    int total = 0;
    int bad   = 0;
    logic [9:0] last_a;

    div_recombiner dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .b     (b),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .a     (a)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs driven and outputs sampled on the falling edge.
    task automatic run_op(input logic [4:0] qi, input logic [4:0] bi, input logic [4:0] ri,
                          input logic [9:0] exp);
        @(negedge clk);
        start = 1'b1; q = qi; b = bi; r = ri;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 5) begin
                check_eq("run_busy", busy, 1);
                check_eq("run_ready", ready, 0);
                check_eq("run_a_hold", a, last_a);
            end else if (c == 6) begin
                check_eq("done_busy", busy, 0);
                check_eq("done_ready", ready, 1);
                check_eq("done_a", a, exp);
            end else begin
                check_eq("idle_ready", ready, 0);
                check_eq("idle_a", a, exp);
            end
        end
        last_a = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
        last_a = 10'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_a", a, 0);
        rst = 1'b0;

        // Scenarios 1 and 2
        run_op(5'd2, 5'd3, 5'd1, 10'd7);
        run_op(5'd31, 5'd31, 5'd31, 10'd992);
        run_op(5'd0, 5'd17, 5'd4, 10'd4);

        // Scenario 3: start held, back-to-back results 7 cycles apart
        @(negedge clk);
        start = 1'b1; q = 5'd1; b = 5'd7; r = 5'd0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) begin
                q = 5'd6; b = 5'd5; r = 5'd0;
            end
            if (c == 8) start = 1'b0;
            check_eq("held_ready", ready, (c == 6 || c == 13) ? 1 : 0);
            check_eq("held_busy", busy, ((c >= 1 && c <= 5) || (c >= 8 && c <= 12)) ? 1 : 0);
            if (c == 6)  check_eq("held_a1", a, 7);
            if (c == 13) check_eq("held_a2", a, 30);
        end
        last_a = 10'd30;

        // Scenario 4: operand change and start during RUN are ignored
        @(negedge clk);
        start = 1'b1; q = 5'd3; b = 5'd3; r = 5'd0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = (c == 2) ? 1'b1 : 1'b0;
            if (c == 2) begin
                q = 5'd5; b = 5'd5; r = 5'd5;
            end
            check_eq("ign_busy", busy, (c <= 5) ? 1 : 0);
            check_eq("ign_ready", ready, (c == 6) ? 1 : 0);
            if (c >= 6) check_eq("ign_a", a, 9);
        end
        last_a = 10'd9;

        // Scenario 5: reset on the 3rd RUN cycle aborts the op
        @(negedge clk);
        start = 1'b1; q = 5'd2; b = 5'd3; r = 5'd1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_eq("pre_abort_busy", busy, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", ready, 0);
        check_eq("abort_a", a, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq("abort_no_ready", ready, 0);
            check_eq("abort_no_busy", busy, 0);
        end
        last_a = 10'd0;
        run_op(5'd4, 5'd4, 5'd3, 10'd19);

        // Scenario 6: result holds through a long idle
        run_op(5'd2, 5'd3, 5'd1, 10'd7);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("hold_a", a, 7);
            check_eq("hold_busy", busy, 0);
            check_eq("hold_ready", ready, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
